// File: rtl/command_sequencer.sv
// Frame-based command sequencer: decodes UART command frames, drives the register
// file and gated ALU, and streams read data / ALU results back to the transmitter.
module command_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int ALU_FUNCTION_WIDTH = 4,
  parameter int ALU_RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] NAK_CODE = DATA_WIDTH'(8'hEE),
  localparam int ADDR_W = (REGISTER_FILE_DEPTH > 1) ? $clog2(REGISTER_FILE_DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          receiver_parallel_data_valid_synchronized,
  input  logic [DATA_WIDTH-1:0]         receiver_parallel_data_synchronized,
  input  logic                          transmitter_busy_synchronized,
  output logic                          transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]         transmitter_parallel_data,
  output logic [ADDR_W-1:0]             register_file_address,
  output logic                          register_file_write_enable,
  output logic [DATA_WIDTH-1:0]         register_file_write_data,
  output logic                          register_file_read_enable,
  input  logic                          register_file_read_data_valid,
  input  logic [DATA_WIDTH-1:0]         register_file_read_data,
  output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
  output logic                          ALU_enable,
  output logic                          ALU_clk_enable,
  input  logic                          ALU_result_valid,
  input  logic [ALU_RESULT_WIDTH-1:0]   ALU_result,
  output logic                          command_error
);

  localparam int RESULT_WORDS = (ALU_RESULT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BUF_W = RESULT_WORDS * DATA_WIDTH;
  localparam int WCNT_W = $clog2(RESULT_WORDS + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] WR_ADDR      = 4'd1;
  localparam logic [3:0] WR_DATA      = 4'd2;
  localparam logic [3:0] RD_ADDR      = 4'd3;
  localparam logic [3:0] RD_WAIT      = 4'd4;
  localparam logic [3:0] OP_A         = 4'd5;
  localparam logic [3:0] OP_B         = 4'd6;
  localparam logic [3:0] FUNC         = 4'd7;
  localparam logic [3:0] ALU_WAIT     = 4'd8;
  localparam logic [3:0] TX_LOAD      = 4'd9;
  localparam logic [3:0] TX_WAIT_BUSY = 4'd10;
  localparam logic [3:0] TX_WAIT_IDLE = 4'd11;

  logic [3:0]        state;
  logic [BUF_W-1:0]  tx_buf;
  logic [WCNT_W-1:0] words_left;
  logic [TMR_W-1:0]  timer;
  logic              alu_start_pending;
  logic              progress;
  logic              timeout_hit;
  logic              overrun_state;
  logic              addr_ok;
  logic [7:0]        opcode;

  logic rx_valid;
  logic busy;
  assign rx_valid = receiver_parallel_data_valid_synchronized;
  assign busy     = transmitter_busy_synchronized;
  assign opcode   = receiver_parallel_data_synchronized[7:0];
  assign addr_ok  = {1'b0, receiver_parallel_data_synchronized} <
                    (DATA_WIDTH + 1)'(REGISTER_FILE_DEPTH);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // progress marks an accepted word or handshake step; it restarts the timeout
  always_comb begin
    progress      = 1'b0;
    overrun_state = 1'b0;
    case (state)
      WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUNC: progress = rx_valid;
      RD_WAIT: begin
        progress      = register_file_read_data_valid;
        overrun_state = 1'b1;
      end
      ALU_WAIT: begin
        progress      = alu_start_pending || ALU_result_valid;
        overrun_state = 1'b1;
      end
      TX_LOAD: begin
        progress      = !busy;
        overrun_state = 1'b1;
      end
      TX_WAIT_BUSY: begin
        progress      = busy;
        overrun_state = 1'b1;
      end
      TX_WAIT_IDLE: begin
        progress      = !busy;
        overrun_state = 1'b1;
      end
      default: progress = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                           <= IDLE;
      tx_buf                          <= '0;
      words_left                      <= '0;
      timer                           <= '0;
      alu_start_pending               <= 1'b0;
      transmitter_parallel_data_valid <= 1'b0;
      transmitter_parallel_data       <= '0;
      register_file_address           <= '0;
      register_file_write_enable      <= 1'b0;
      register_file_write_data        <= '0;
      register_file_read_enable       <= 1'b0;
      ALU_function                    <= '0;
      ALU_enable                      <= 1'b0;
      ALU_clk_enable                  <= 1'b0;
      command_error                   <= 1'b0;
    end else begin
      register_file_write_enable      <= 1'b0;
      register_file_read_enable       <= 1'b0;
      ALU_enable                      <= 1'b0;
      transmitter_parallel_data_valid <= 1'b0;
      command_error                   <= 1'b0;

      if (state == IDLE || progress) timer <= '0;
      else timer <= timer + 1'b1;

      if (state != IDLE && !progress && timeout_hit) begin
        state             <= IDLE;
        timer             <= '0;
        command_error     <= 1'b1;
        ALU_clk_enable    <= 1'b0;
        alu_start_pending <= 1'b0;
      end else begin
        if (overrun_state && rx_valid) command_error <= 1'b1;
        case (state)
          IDLE: if (rx_valid) begin
            case (opcode)
              8'hAA:   state <= WR_ADDR;
              8'hBB:   state <= RD_ADDR;
              8'hCC:   state <= OP_A;
              8'hDD:   state <= FUNC;
              default: command_error <= 1'b1;
            endcase
          end
          WR_ADDR, RD_ADDR: if (rx_valid) begin
            if (!addr_ok) begin
              command_error <= 1'b1;
              tx_buf        <= BUF_W'(NAK_CODE);
              words_left    <= WCNT_W'(1);
              state         <= TX_LOAD;
            end else begin
              register_file_address <= receiver_parallel_data_synchronized[ADDR_W-1:0];
              if (state == RD_ADDR) begin
                register_file_read_enable <= 1'b1;
                state                     <= RD_WAIT;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          WR_DATA: if (rx_valid) begin
            register_file_write_data   <= receiver_parallel_data_synchronized;
            register_file_write_enable <= 1'b1;
            state                      <= IDLE;
          end
          RD_WAIT: if (register_file_read_data_valid) begin
            tx_buf     <= BUF_W'(register_file_read_data);
            words_left <= WCNT_W'(1);
            state      <= TX_LOAD;
          end
          OP_A, OP_B: if (rx_valid) begin
            register_file_address      <= (state == OP_A) ? ADDR_W'(0) : ADDR_W'(1);
            register_file_write_data   <= receiver_parallel_data_synchronized;
            register_file_write_enable <= 1'b1;
            state                      <= (state == OP_A) ? OP_B : FUNC;
          end
          FUNC: if (rx_valid) begin
            ALU_function      <= receiver_parallel_data_synchronized[ALU_FUNCTION_WIDTH-1:0];
            ALU_clk_enable    <= 1'b1;
            alu_start_pending <= 1'b1;
            state             <= ALU_WAIT;
          end
          // Start pulse goes out one cycle after the gated clock is enabled
          ALU_WAIT: begin
            if (alu_start_pending) begin
              ALU_enable        <= 1'b1;
              alu_start_pending <= 1'b0;
            end else if (ALU_result_valid) begin
              tx_buf         <= BUF_W'(ALU_result);
              words_left     <= WCNT_W'(RESULT_WORDS);
              ALU_clk_enable <= 1'b0;
              state          <= TX_LOAD;
            end
          end
          TX_LOAD: if (!busy) begin
            transmitter_parallel_data       <= tx_buf[DATA_WIDTH-1:0];
            transmitter_parallel_data_valid <= 1'b1;
            tx_buf                          <= tx_buf >> DATA_WIDTH;
            words_left                      <= words_left - 1'b1;
            state                           <= TX_WAIT_BUSY;
          end
          TX_WAIT_BUSY: if (busy) state <= TX_WAIT_IDLE;
          TX_WAIT_IDLE: if (!busy) state <= (words_left == '0) ? IDLE : TX_LOAD;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer with small register-file, ALU and UART-transmitter models.
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        busy = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [3:0]  rf_addr;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic        rf_re;
  logic        rf_valid = 1'b0;
  logic [7:0]  rf_rdata = '0;
  logic [3:0]  alu_func;
  logic        alu_en;
  logic        alu_clk_en;
  logic        alu_valid = 1'b0;
  logic [15:0] alu_result = '0;
  logic        cmd_err;

  int          checks = 0;
  int          errors = 0;

  logic [7:0]  mem [16];
  logic [7:0]  tx_q [$];
  logic [3:0]  wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          err_cnt = 0;
  int          alu_cnt = 0;
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  logic [15:0] alu_value = '0;

  command_sequencer #(
    .DATA_WIDTH(8),
    .REGISTER_FILE_DEPTH(16),
    .ALU_FUNCTION_WIDTH(4),
    .ALU_RESULT_WIDTH(16),
    .TIMEOUT_CYCLES(16),
    .NAK_CODE(8'hEE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .receiver_parallel_data_valid_synchronized(rx_valid),
    .receiver_parallel_data_synchronized(rx_data),
    .transmitter_busy_synchronized(busy),
    .transmitter_parallel_data_valid(tx_valid),
    .transmitter_parallel_data(tx_data),
    .register_file_address(rf_addr),
    .register_file_write_enable(rf_we),
    .register_file_write_data(rf_wdata),
    .register_file_read_enable(rf_re),
    .register_file_read_data_valid(rf_valid),
    .register_file_read_data(rf_rdata),
    .ALU_function(alu_func),
    .ALU_enable(alu_en),
    .ALU_clk_enable(alu_clk_en),
    .ALU_result_valid(alu_valid),
    .ALU_result(alu_result),
    .command_error(cmd_err)
  );

  always #5 clk = ~clk;

  // Peripheral models observe and respond on the falling edge, clear of the DUT's rising edge
  always @(negedge clk) begin
    if (rf_we) begin
      mem[rf_addr] = rf_wdata;
      wr_addr_q.push_back(rf_addr);
      wr_data_q.push_back(rf_wdata);
    end
    rf_valid = rf_re;
    if (rf_re) rf_rdata = mem[rf_addr];
    alu_valid = alu_en;
    if (alu_en) begin
      alu_cnt++;
      alu_result = alu_value;
    end
    if (cmd_err) err_cnt++;
    if (tx_valid) begin
      tx_q.push_back(tx_data);
      busy_cnt = 4;
    end
    if (busy_cnt > 0) busy_cnt--;
    busy = hold_busy || (busy_cnt != 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle receive pulse; returns 2 time units after the edge that sampled it
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  initial begin
    int tx_base;
    int wr_base;
    int err_base;
    int cnt;

    waitCycles(3);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_rf_addr", rf_addr, 0);
    checkOutput("reset_rf_we", rf_we, 0);
    checkOutput("reset_rf_wdata", rf_wdata, 0);
    checkOutput("reset_rf_re", rf_re, 0);
    checkOutput("reset_alu", {alu_func, alu_en, alu_clk_en}, 0);
    checkOutput("reset_err", cmd_err, 0);
    reset = 1'b0;
    waitCycles(2);

    applyStimulus(8'hAA);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    checkOutput("wr_strobe", rf_we, 1);
    checkOutput("wr_addr", rf_addr, 5);
    checkOutput("wr_data", rf_wdata, 8'h3C);
    waitCycles(1);
    checkOutput("wr_strobe_one_cycle", rf_we, 0);

    tx_base = tx_q.size();
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    checkOutput("rd_strobe", rf_re, 1);
    checkOutput("rd_addr", rf_addr, 5);
    waitCycles(15);
    checkOutput("rd_tx_count", tx_q.size() - tx_base, 1);
    checkOutput("rd_tx_word", tx_q[tx_base], 8'h3C);

    tx_base = tx_q.size();
    wr_base = wr_addr_q.size();
    alu_value = 16'h0013;
    applyStimulus(8'hCC);
    applyStimulus(8'h10);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    checkOutput("alu_clk_en_rise", alu_clk_en, 1);
    checkOutput("alu_en_not_yet", alu_en, 0);
    checkOutput("alu_func", alu_func, 0);
    waitCycles(1);
    checkOutput("alu_en_pulse", alu_en, 1);
    waitCycles(20);
    checkOutput("alu_writes", wr_addr_q.size() - wr_base, 2);
    checkOutput("alu_wr0", {wr_addr_q[wr_base], wr_data_q[wr_base]}, {4'd0, 8'h10});
    checkOutput("alu_wr1", {wr_addr_q[wr_base+1], wr_data_q[wr_base+1]}, {4'd1, 8'h03});
    checkOutput("alu_count", alu_cnt, 1);
    checkOutput("alu_tx_count", tx_q.size() - tx_base, 2);
    checkOutput("alu_tx_lsw", tx_q[tx_base], 8'h13);
    checkOutput("alu_tx_msw", tx_q[tx_base+1], 8'h00);
    checkOutput("alu_clk_en_low", alu_clk_en, 0);

    err_base = err_cnt;
    applyStimulus(8'h42);
    checkOutput("bad_opcode_err", cmd_err, 1);
    waitCycles(2);

    tx_base = tx_q.size();
    wr_base = wr_addr_q.size();
    err_base = err_cnt;
    applyStimulus(8'hAA);
    applyStimulus(8'h14);
    checkOutput("range_err_pulse", cmd_err, 1);
    waitCycles(15);
    checkOutput("range_err_count", err_cnt - err_base, 1);
    checkOutput("range_tx_count", tx_q.size() - tx_base, 1);
    checkOutput("range_nak", tx_q[tx_base], 8'hEE);
    checkOutput("range_no_write", wr_addr_q.size() - wr_base, 0);

    err_base = err_cnt;
    applyStimulus(8'hAA);
    cnt = 0;
    while (!cmd_err && cnt < 40) begin
      waitCycles(1);
      cnt++;
    end
    checkOutput("timeout_cycles", cnt, 16);
    waitCycles(2);
    checkOutput("timeout_err_count", err_cnt - err_base, 1);
    tx_base = tx_q.size();
    applyStimulus(8'hBB);
    applyStimulus(8'h00);
    checkOutput("post_timeout_rd", rf_re, 1);
    waitCycles(15);
    checkOutput("post_timeout_tx", {tx_q.size() - tx_base, 8'(tx_q[tx_base])}, {32'd1, 8'h10});

    tx_base = tx_q.size();
    wr_base = wr_addr_q.size();
    err_base = err_cnt;
    alu_value = 16'hA55A;
    hold_busy = 1'b1;
    applyStimulus(8'hDD);
    applyStimulus(8'h01);
    waitCycles(3);
    applyStimulus(8'h77);
    checkOutput("overrun_err_pulse", cmd_err, 1);
    waitCycles(2);
    checkOutput("overrun_no_tx_yet", tx_q.size() - tx_base, 0);
    hold_busy = 1'b0;
    waitCycles(20);
    checkOutput("overrun_err_count", err_cnt - err_base, 1);
    checkOutput("overrun_tx_count", tx_q.size() - tx_base, 2);
    checkOutput("overrun_tx_lsw", tx_q[tx_base], 8'h5A);
    checkOutput("overrun_tx_msw", tx_q[tx_base+1], 8'hA5);
    checkOutput("overrun_no_write", wr_addr_q.size() - wr_base, 0);

    wr_base = wr_addr_q.size();
    applyStimulus(8'hCC);
    applyStimulus(8'h22);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    waitCycles(1);
    rx_valid = 1'b0;
    checkOutput("rst_opb_outputs",
                {tx_valid, tx_data, rf_addr, rf_we, rf_wdata, rf_re, alu_func, alu_en, alu_clk_en, cmd_err},
                0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("rst_opb_writes", wr_addr_q.size() - wr_base, 1);
    checkOutput("rst_opb_wr0", {wr_addr_q[wr_base], wr_data_q[wr_base]}, {4'd0, 8'h22});
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    applyStimulus(8'h99);
    checkOutput("post_reset_write", {rf_we, rf_addr, rf_wdata}, {1'b1, 4'd3, 8'h99});

    waitCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
